load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU. Takes ALUout as the effective address
//  and rd2 as store data, and runs one LB/LH/LW/LBU/LHU/SB/SH/SW per request.
//  Talks to a word-wide data bus with a req/ack handshake. Stalls the core until the
//  access completes, then returns load data, sign- or zero-extended, for writeback.
// PARAMETERS
//  DATA_WIDTH  32  data path width; only 32 is supported (4 byte lanes)
//  ADDR_WIDTH  32  byte-address width
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  mem_read   in   1           load request (held stable while stall=1)
//  mem_write  in   1           store request (held stable while stall=1)
//  funct3     in   3           access size/sign (RV32I load/store encoding)
//  ALUout     in   ADDR_WIDTH  effective byte address
//  wdata      in   DATA_WIDTH  store data (rd2)
//  stall      out  1           freeze PC/pipeline while access in flight
//  ld_valid   out  1           1-cycle pulse: ld_data valid
//  ld_data    out  DATA_WIDTH  extended load result, held until next load completes
//  err        out  1           1-cycle pulse: misaligned / illegal access
//  bus_req    out  1           bus request
//  bus_we     out  1           1 = write
//  bus_addr   out  ADDR_WIDTH  word address; bits [1:0] always 0
//  bus_be     out  4           byte enables
//  bus_wdata  out  DATA_WIDTH  lane-replicated store data
//  bus_ack    in   1           completion; with bus_rdata on reads
//  bus_rdata  in   DATA_WIDTH  read word
// BEHAVIOUR
//  - Reset: state IDLE; every output 0, including ld_data.
//  - FSM: IDLE -> BUS -> DONE -> IDLE, plus IDLE -> ERR -> IDLE.
//  - IDLE, request present (mem_read|mem_write):
//    - Illegal if any of:
//      - both mem_read and mem_write are 1;
//      - funct3 is 011, 110 or 111, or a store funct3 above 010;
//      - half access with addr[0]=1;
//      - word access with addr[1:0]!=0.
//    - Illegal -> ERR. No bus cycle. stall=0 in this cycle.
//    - Legal -> register addr/be/wdata/we; go to BUS. stall=1.
//  - BUS:
//    - bus_req=1. addr/we/be/wdata stay constant until ack.
//    - On bus_ack, capture the extended bus_rdata (loads only) and go to DONE.
//    - stall=1 throughout BUS.
//  - DONE: stall=0; ld_valid=1 for loads only; next state IDLE. DONE never relaunches
//    a request, even though the core's inputs still show the same instruction.
//  - ERR: err=1; next state IDLE.
//  - Latency:
//    - Request seen at cycle t; bus_req at t+1.
//    - Zero-wait ack at t+1 gives DONE at t+2, so a minimum of 2 stall cycles.
//    - Each extra wait cycle adds 1.
//  - bus_ack outside BUS is ignored.
//  - Byte enables: SB 0001<<a[1:0]; SH 0011<<a[1:0]; SW 1111.
//  - Store data: SB {4{b}}, SH {2{h}}, SW as-is.
//  - Load data:
//    - select the lane by a[1:0];
//    - LB/LH sign-extend from bit 7/15;
//    - LBU/LHU zero-extend;
//    - LW passes the word through.
//  - Reset mid-access: bus_req drops asynchronously; FSM goes to IDLE; any later ack is
//    ignored; ld_data is cleared.
//  - No request in IDLE: stall=0, bus idle.
// STRUCTURE
//  - Shared package lsu_pkg:
//    - f3_e enum: LB=000, LH=001, LW=010, LBU=100, LHU=101 (stores reuse 000/001/010);
//    - lsu_state_e enum {IDLE, BUS, DONE, ERR};
//    - BE_BYTE/BE_HALF/BE_WORD constants.
//  - Sub-module lsu_align (combinational):
//    - inputs funct3, a[1:0], wdata, rdata;
//    - outputs be, store lanes, extended load data, misaligned/illegal flag.
//  - load_store_unit itself holds the FSM and the registers.
// TESTING
//  - LW @0x100, zero-wait ack, rdata=0xDEADBEEF:
//    bus_addr=0x100, be=1111, stall 2 cycles, ld_valid with ld_data=0xDEADBEEF.
//  - LB @0x103, rdata=0x80FF_0000:
//    be=1000, ld_data=0xFFFFFF80.
//  - LBU @0x103, same rdata:
//    ld_data=0x00000080.
//  - SH @0x102, wdata=0x1234ABCD, 3 wait cycles:
//    bus_we=1, be=1100, bus_wdata=0xABCDABCD, stall 5 cycles, no ld_valid.
//  - LW @0x102, and separately mem_read=mem_write=1:
//    err pulse, bus_req never asserted, stall=0 throughout.
//  - rst asserted during BUS with ack pending:
//    bus_req=0 the same cycle; a later bus_ack gives no ld_valid; ld_data=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I access encodings, FSM states and byte-enable patterns.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } f3_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load data
// and the per-access legality check for one 32-bit word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o,
  output logic        illegal_o
);

  logic [31:0] lane_s;

  assign lane_s = rdata_i >> {lane_i, 3'b000};

  // Decode access size/sign into enables, store lanes, load extension and legality.
  always_comb begin
    be_o      = 4'b0000;
    st_data_o = wdata_i;
    ld_data_o = rdata_i;
    illegal_o = 1'b0;
    case (funct3_i)
      LB: begin
        be_o      = BE_BYTE << lane_i;
        st_data_o = {4{wdata_i[7:0]}};
        ld_data_o = {{24{lane_s[7]}}, lane_s[7:0]};
      end
      LH: begin
        be_o      = BE_HALF << lane_i;
        st_data_o = {2{wdata_i[15:0]}};
        ld_data_o = {{16{lane_s[15]}}, lane_s[15:0]};
        illegal_o = lane_i[0];
      end
      LW: begin
        be_o      = BE_WORD;
        illegal_o = (lane_i != 2'b00);
      end
      // Unsigned encodings exist only for loads.
      LBU: begin
        be_o      = BE_BYTE << lane_i;
        ld_data_o = {24'h000000, lane_s[7:0]};
        illegal_o = is_store_i;
      end
      LHU: begin
        be_o      = BE_HALF << lane_i;
        ld_data_o = {16'h0000, lane_s[15:0]};
        illegal_o = is_store_i | lane_i[0];
      end
      default: begin
        be_o      = 4'b0000;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: runs one load or store per request over a req/ack word bus,
// stalling the core until the access completes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] ALUout,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lane_q;
  logic [2:0]            f3_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] ld_data_q;

  logic [2:0]            sel_f3_s;
  logic [1:0]            sel_lane_s;
  logic                  sel_store_s;
  logic [3:0]            al_be_s;
  logic [DATA_WIDTH-1:0] al_st_s;
  logic [DATA_WIDTH-1:0] al_ld_s;
  logic                  al_illegal_s;
  logic                  launch_s;
  logic                  capture_s;
  logic                  stall_s;

  // Aligner sees the live request in IDLE and the latched access afterwards.
  always_comb begin
    if (state_q == IDLE) begin
      sel_f3_s    = funct3;
      sel_lane_s  = ALUout[1:0];
      sel_store_s = mem_write;
    end else begin
      sel_f3_s    = f3_q;
      sel_lane_s  = lane_q;
      sel_store_s = we_q;
    end
  end

  lsu_align u_align (
    .funct3_i  (sel_f3_s),
    .is_store_i(sel_store_s),
    .lane_i    (sel_lane_s),
    .wdata_i   (wdata),
    .rdata_i   (bus_rdata),
    .be_o      (al_be_s),
    .st_data_o (al_st_s),
    .ld_data_o (al_ld_s),
    .illegal_o (al_illegal_s)
  );

  // Next-state, stall and register-enable decode.
  always_comb begin
    state_d   = state_q;
    stall_s   = 1'b0;
    launch_s  = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          if ((mem_read & mem_write) | al_illegal_s) begin
            state_d = ERR;
          end else begin
            state_d  = BUS;
            stall_s  = 1'b1;
            launch_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        stall_s = 1'b1;
        if (bus_ack) begin
          state_d   = DONE;
          capture_s = ~we_q;
        end else begin
          state_d = BUS;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and access registers; reset abandons any in-flight bus cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch_s) begin
        addr_q  <= {ALUout[ADDR_WIDTH-1:2], 2'b00};
        lane_q  <= ALUout[1:0];
        f3_q    <= funct3;
        be_q    <= al_be_s;
        wdata_q <= al_st_s;
        we_q    <= mem_write;
      end
      if (capture_s) begin
        ld_data_q <= al_ld_s;
      end
    end
  end

  assign stall     = stall_s;
  assign bus_req   = (state_q == BUS);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign ld_valid  = (state_q == DONE) & ~we_q;
  assign err       = (state_q == ERR);
  assign ld_data   = ld_data_q;

endmodule
